// File: rtl/vga_pkg.sv
// vga_pkg: shared scan states and default 640x480@60 timing for the display path.
package vga_pkg;
  typedef enum logic {STARTUP, RUN} scan_state_e;
  localparam int LINE_PIXELS = 640;
  localparam int FRAME_LINES = 480;
  localparam int H_FRONT = 16;
  localparam int H_SYNC = 96;
  localparam int H_BACK = 48;
  localparam int V_FRONT = 10;
  localparam int V_SYNC = 2;
  localparam int V_BACK = 33;
endpackage

// File: rtl/vga_timing_counter.sv
// vga_timing_counter: raster h/v counters with hold, active-area, sync-window and last flags.
module vga_timing_counter
  import vga_pkg::*;
#(
  parameter int line_pixels_p = LINE_PIXELS,
  parameter int frame_lines_p = FRAME_LINES,
  parameter int h_front_p = H_FRONT,
  parameter int h_sync_p = H_SYNC,
  parameter int h_back_p = H_BACK,
  parameter int v_front_p = V_FRONT,
  parameter int v_sync_p = V_SYNC,
  parameter int v_back_p = V_BACK,
  localparam int h_total_lp = line_pixels_p + h_front_p + h_sync_p + h_back_p,
  localparam int v_total_lp = frame_lines_p + v_front_p + v_sync_p + v_back_p,
  localparam int hw_lp = $clog2(h_total_lp),
  localparam int vw_lp = $clog2(v_total_lp)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             hold_i,
  output logic [hw_lp-1:0] h_o,
  output logic [vw_lp-1:0] v_o,
  output logic             active_o,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             h_last_o,
  output logic             v_last_o
);
  assign h_last_o = h_o == hw_lp'(h_total_lp - 1);
  assign v_last_o = v_o == vw_lp'(v_total_lp - 1);
  assign active_o = h_o < hw_lp'(line_pixels_p) && v_o < vw_lp'(frame_lines_p);
  assign hsync_o = h_o >= hw_lp'(line_pixels_p + h_front_p) &&
                   h_o < hw_lp'(line_pixels_p + h_front_p + h_sync_p);
  assign vsync_o = v_o >= vw_lp'(frame_lines_p + v_front_p) &&
                   v_o < vw_lp'(frame_lines_p + v_front_p + v_sync_p);
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      h_o <= '0;
      v_o <= '0;
    end else if (!hold_i) begin
      h_o <= h_last_o ? '0 : h_o + hw_lp'(1);
      if (h_last_o) v_o <= v_last_o ? '0 : v_o + vw_lp'(1);
    end
  end
endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: scans a valid/ready grayscale stream onto VGA with registered sync/RGB and sticky underflow.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int pixel_width_p = 16,
  parameter int line_pixels_p = LINE_PIXELS,
  parameter int frame_lines_p = FRAME_LINES,
  parameter int h_front_p = H_FRONT,
  parameter int h_sync_p = H_SYNC,
  parameter int h_back_p = H_BACK,
  parameter int v_front_p = V_FRONT,
  parameter int v_sync_p = V_SYNC,
  parameter int v_back_p = V_BACK,
  parameter int color_bits_p = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [pixel_width_p-1:0] pixel_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  output logic [color_bits_p-1:0]  red_o,
  output logic [color_bits_p-1:0]  green_o,
  output logic [color_bits_p-1:0]  blue_o,
  output logic                     hsync_o,
  output logic                     vsync_o,
  output logic                     active_o,
  output logic                     frame_start_o,
  output logic                     underflow_o
);
  localparam int hw_lp = $clog2(line_pixels_p + h_front_p + h_sync_p + h_back_p);
  localparam int vw_lp = $clog2(frame_lines_p + v_front_p + v_sync_p + v_back_p);
  scan_state_e state_q, state_d;
  logic [hw_lp-1:0] h;
  logic [vw_lp-1:0] v;
  logic active, in_hsync, in_vsync, run, take;
  logic h_last_unused, v_last_unused, pixel_unused;
  logic [color_bits_p-1:0] gray;
  vga_timing_counter #(
    .line_pixels_p(line_pixels_p), .frame_lines_p(frame_lines_p),
    .h_front_p(h_front_p), .h_sync_p(h_sync_p), .h_back_p(h_back_p),
    .v_front_p(v_front_p), .v_sync_p(v_sync_p), .v_back_p(v_back_p)
  ) u_timing (
    .clk_i(clk_i), .reset_i(reset_i), .hold_i(!run),
    .h_o(h), .v_o(v), .active_o(active),
    .hsync_o(in_hsync), .vsync_o(in_vsync),
    .h_last_o(h_last_unused), .v_last_o(v_last_unused)
  );
  // Raster stays parked at (0,0) until the stream first presents data.
  always_comb state_d = (state_q == STARTUP && valid_i) ? RUN : state_q;
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= STARTUP;
    else state_q <= state_d;
  end
  assign run = state_q == RUN;
  assign ready_o = run && active;
  assign take = ready_o && valid_i;
  assign gray = pixel_i[pixel_width_p-1 -: color_bits_p];
  assign pixel_unused = ^pixel_i;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      red_o <= '0;
      green_o <= '0;
      blue_o <= '0;
      hsync_o <= 1'b1;
      vsync_o <= 1'b1;
      active_o <= 1'b0;
      frame_start_o <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      red_o <= take ? gray : '0;
      green_o <= take ? gray : '0;
      blue_o <= take ? gray : '0;
      hsync_o <= !(run && in_hsync);
      vsync_o <= !(run && in_vsync);
      active_o <= ready_o;
      frame_start_o <= run && h == '0 && v == '0;
      underflow_o <= underflow_o || (ready_o && !valid_i);
    end
  end
endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: directed checks of scanout timing, color mapping, underflow and reset on a reduced raster.
module tb_vga_scanout;
  localparam int LP = 8, FL = 4, HF = 2, HS = 3, HB = 2, VF = 1, VS = 2, VB = 1;
  localparam int HT = LP + HF + HS + HB;
  localparam int VT = FL + VF + VS + VB;
  localparam int FR = HT * VT;
  localparam logic [16:0] RST_V = {12'h000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic clk = 1'b0;
  logic reset_i = 1'b1;
  logic [15:0] pixel_i = '0;
  logic valid_i = 1'b0;
  logic ready_o, hsync_o, vsync_o, active_o, frame_start_o, underflow_o;
  logic [3:0] red_o, green_o, blue_o;
  logic [16:0] out_v;
  int n_cmp = 0, n_err = 0, cyc = 0;
  logic exp_uf = 1'b0;
  vga_scanout #(
    .pixel_width_p(16), .line_pixels_p(LP), .frame_lines_p(FL),
    .h_front_p(HF), .h_sync_p(HS), .h_back_p(HB),
    .v_front_p(VF), .v_sync_p(VS), .v_back_p(VB), .color_bits_p(4)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .pixel_i(pixel_i), .valid_i(valid_i),
    .ready_o(ready_o), .red_o(red_o), .green_o(green_o), .blue_o(blue_o),
    .hsync_o(hsync_o), .vsync_o(vsync_o), .active_o(active_o),
    .frame_start_o(frame_start_o), .underflow_o(underflow_o)
  );
  always #5 clk = ~clk;
  assign out_v = {red_o, green_o, blue_o, hsync_o, vsync_o, active_o, frame_start_o, underflow_o};
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic is_act(input int c);
    return (c % HT) < LP && ((c / HT) % VT) < FL;
  endfunction
  function automatic logic [16:0] exp_out(input int c, input logic [15:0] pix, input logic vld, input logic uf);
    int h = c % HT;
    int v = (c / HT) % VT;
    logic act = h < LP && v < FL;
    logic [3:0] g = (act && vld) ? pix[15:12] : 4'h0;
    return {g, g, g, !(h >= LP + HF && h < LP + HF + HS), !(v >= FL + VF && v < FL + VF + VS),
            act, h == 0 && v == 0, uf};
  endfunction
  function automatic logic [15:0] pix_at(input int h, input int v);
    if (h == 5 && v == 3) return 16'h0008;
    if (h == 1 && v == 0) return 16'hF123;
    if (h == 2 && v == 0) return 16'hA5FF;
    return 16'(((h + v) & 15) << 12) | 16'h0321;
  endfunction
  task automatic test_reset();
    reset_i = 1'b1;
    valid_i = 1'b0;
    repeat (5) tick();
    n_cmp++;
    if ({ready_o, out_v} !== {1'b0, RST_V}) begin
      n_err++;
      $display("FAIL reset_values: got ready=%b out=%h want ready=0 out=%h", ready_o, out_v, RST_V);
    end
    reset_i = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      n_cmp++;
      if ({ready_o, out_v} !== {1'b0, RST_V}) begin
        n_err++;
        $display("FAIL startup_idle[%0d]: got ready=%b out=%h want ready=0 out=%h", i, ready_o, out_v, RST_V);
      end
    end
  endtask
  task automatic test_start();
    pixel_i = pix_at(0, 0);
    valid_i = 1'b1;
    n_cmp++;
    if (ready_o !== 1'b0) begin
      n_err++;
      $display("FAIL ready_before_run: got %b want 0", ready_o);
    end
    tick();
    cyc = 0;
    n_cmp++;
    if ({ready_o, active_o, frame_start_o} !== 3'b100) begin
      n_err++;
      $display("FAIL run_entry: got ready/active/fs=%b%b%b want 100", ready_o, active_o, frame_start_o);
    end
  endtask
  task automatic test_frames();
    int xfers = 0, hs_low = 0, vs_low = 0, last_fs = -1;
    logic [16:0] e;
    for (int i = 0; i < 2 * FR; i++) begin
      pixel_i = pix_at(cyc % HT, (cyc / HT) % VT);
      valid_i = 1'b1;
      n_cmp++;
      if (ready_o !== is_act(cyc)) begin
        n_err++;
        $display("FAIL frame_ready[%0d]: got %b want %b", cyc, ready_o, is_act(cyc));
      end
      if (is_act(cyc)) xfers++;
      e = exp_out(cyc, pixel_i, 1'b1, exp_uf);
      tick();
      cyc++;
      n_cmp++;
      if (out_v !== e) begin
        n_err++;
        $display("FAIL frame_out[%0d]: got %h want %h", cyc - 1, out_v, e);
      end
      hs_low += int'(!hsync_o);
      vs_low += int'(!vsync_o);
      if (frame_start_o) begin
        if (last_fs >= 0) begin
          n_cmp++;
          if (i - last_fs != FR) begin
            n_err++;
            $display("FAIL frame_period: got %0d want %0d", i - last_fs, FR);
          end
        end
        last_fs = i;
      end
    end
    n_cmp++;
    if (xfers != 2 * LP * FL || hs_low != 2 * HS * VT || vs_low != 2 * VS * HT) begin
      n_err++;
      $display("FAIL frame_counts: got xfers=%0d hs=%0d vs=%0d want %0d %0d %0d",
               xfers, hs_low, vs_low, 2 * LP * FL, 2 * HS * VT, 2 * VS * HT);
    end
  endtask
  task automatic test_underflow();
    int idx = 0;
    logic [16:0] e;
    for (int i = 0; i < FR; i++) begin
      valid_i = !((cyc % HT) == 3 && (cyc / HT) % VT == 0);
      pixel_i = 16'((idx & 15) << 12) | 16'h0321;
      n_cmp++;
      if (ready_o !== is_act(cyc)) begin
        n_err++;
        $display("FAIL uf_ready[%0d]: got %b want %b", cyc, ready_o, is_act(cyc));
      end
      if (is_act(cyc) && !valid_i) exp_uf = 1'b1;
      e = exp_out(cyc, pixel_i, valid_i, exp_uf);
      if (is_act(cyc) && valid_i) idx++;
      tick();
      cyc++;
      n_cmp++;
      if (out_v !== e) begin
        n_err++;
        $display("FAIL uf_out[%0d]: got %h want %h", cyc - 1, out_v, e);
      end
    end
    n_cmp++;
    if (idx != LP * FL - 1 || underflow_o !== 1'b1) begin
      n_err++;
      $display("FAIL uf_totals: got xfers=%0d uf=%b want %0d 1", idx, underflow_o, LP * FL - 1);
    end
  endtask
  task automatic test_reset_mid();
    valid_i = 1'b1;
    for (int i = 0; i < 2 * HT + 3; i++) begin
      pixel_i = pix_at(cyc % HT, (cyc / HT) % VT);
      tick();
      cyc++;
    end
    reset_i = 1'b1;
    tick();
    n_cmp++;
    if ({ready_o, out_v} !== {1'b0, RST_V}) begin
      n_err++;
      $display("FAIL mid_reset: got ready=%b out=%h want ready=0 out=%h", ready_o, out_v, RST_V);
    end
    reset_i = 1'b0;
    valid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if ({ready_o, out_v} !== {1'b0, RST_V}) begin
        n_err++;
        $display("FAIL post_reset_idle[%0d]: got ready=%b out=%h want ready=0 out=%h", i, ready_o, out_v, RST_V);
      end
    end
    pixel_i = 16'hB000;
    valid_i = 1'b1;
    tick();
    n_cmp++;
    if (ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL restart_ready: got %b want 1", ready_o);
    end
    tick();
    n_cmp++;
    if (out_v !== {12'hBBB, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL restart_first_pixel: got %h want %h", out_v, {12'hBBB, 5'b11110});
    end
  endtask
  initial begin
    test_reset();
    test_start();
    test_frames();
    test_underflow();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
